// File: rtl/wave_sample_prep.sv
// wave_sample_prep
// Conditions 12-bit microphone samples into the 10-bit waveform stream:
// an optional boxcar average, scaling to 10 bits, and a DEPTH-sample record
// that is replayed with period DEPTH while the display is frozen. The replay
// rewrites the downstream circular sample memory with identical data, so the
// displayed trace holds still.
// Compile-time option: define WAVE_AVG_EN to build the boxcar averager
// (3-cycle latency); leave it undefined for the direct path (2-cycle latency).
module wave_sample_prep #(
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 1280
) (
    input  logic        clk_sample,
    input  logic        reset,
    input  logic [11:0] MIC_in,
    input  logic        freeze,
    output logic [9:0]  wave_sample,
    output logic        frozen,
    output logic        ready
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [11:0]       s0_r;
    logic [11:0]       avg_s;
    logic [9:0]        scaled_s;
    logic              meta_r;
    logic              fz_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  ptr_nx_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nx_s;
    logic              ready_r;
    logic              frozen_r;
    logic [9:0]        wave_r;
    logic [9:0]        rd_r;
    logic [9:0]        mem_r [DEPTH];
    logic              valid_s;

    // Input register: capture the raw microphone sample.
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            s0_r <= 12'h000;
        end else begin
            s0_r <= MIC_in;
        end
    end

`ifdef WAVE_AVG_EN
    localparam int WIN   = 1 << AVG_LOG2;
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int VLD_W = 2;

    logic [11:0]      dly_r [WIN];
    logic [ACC_W-1:0] acc_r;

    // Boxcar: running sum of the last WIN input samples; the oldest sample
    // leaves the sum as the newest enters, so the sum can never overflow.
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
            for (int i = 0; i < WIN; i++) begin
                dly_r[i] <= 12'h000;
            end
        end else begin
            acc_r    <= acc_r + ACC_W'(s0_r) - ACC_W'(dly_r[WIN-1]);
            dly_r[0] <= s0_r;
            for (int i = 1; i < WIN; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    assign avg_s = 12'(acc_r >> AVG_LOG2);
`else
    localparam int VLD_W = 1;

    // AVG_LOG2 has no effect without the averaging stage.
    logic [7:0] unused_cfg_s;
    assign unused_cfg_s = 8'(AVG_LOG2);

    assign avg_s = s0_r;
`endif

    // Truncating scale from 12 to 10 bits.
    assign scaled_s = 10'(avg_s >> 2'd2);

    logic [VLD_W-1:0] vld_r;

    // Pipeline fill tracker: marks when the output reflects real input.
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            vld_r <= {VLD_W{1'b0}};
        end else begin
            vld_r <= VLD_W'({vld_r, 1'b1});
        end
    end

    assign valid_s = vld_r[VLD_W-1];

    // Two-flop synchronizer for the asynchronous freeze switch.
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            meta_r <= 1'b0;
            fz_r   <= 1'b0;
        end else begin
            meta_r <= freeze;
            fz_r   <= meta_r;
        end
    end

    // Next-state logic: freezing is only allowed once the record is full.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (fz_r && ready_r) begin
                    state_nx_s = ST_FROZEN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FROZEN: begin
                if (!fz_r) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_FROZEN;
                end
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // Record pointer and fill count for the coming edge.
    always_comb begin
        ptr_nx_s  = ptr_r;
        fill_nx_s = fill_r;
        if (ptr_r == PTR_W'(DEPTH - 1)) begin
            ptr_nx_s = {PTR_W{1'b0}};
        end else begin
            ptr_nx_s = ptr_r + PTR_W'(1'b1);
        end
        if ((state_nx_s == ST_RUN) && valid_s && (fill_r != FILL_W'(DEPTH))) begin
            fill_nx_s = fill_r + FILL_W'(1'b1);
        end else begin
            fill_nx_s = fill_r;
        end
    end

    // State, pointer, fill and output registers. The output source follows
    // the next state so the first replayed or live sample appears on the
    // same edge the state changes.
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            state_r  <= ST_RUN;
            ptr_r    <= {PTR_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
            ready_r  <= 1'b0;
            frozen_r <= 1'b0;
            wave_r   <= 10'd0;
        end else begin
            state_r  <= state_nx_s;
            ptr_r    <= ptr_nx_s;
            fill_r   <= fill_nx_s;
            ready_r  <= (fill_nx_s == FILL_W'(DEPTH));
            frozen_r <= (state_nx_s == ST_FROZEN);
            if (state_nx_s == ST_RUN) begin
                wave_r <= scaled_s;
            end else begin
                wave_r <= rd_r;
            end
        end
    end

    // Record memory: written at ptr while running; read one address ahead
    // every cycle so replay data is already registered when it is needed.
    always_ff @(posedge clk_sample) begin
        if (!reset && (state_nx_s == ST_RUN)) begin
            mem_r[ptr_r] <= scaled_s;
        end
        rd_r <= mem_r[ptr_nx_s];
    end

    assign wave_sample = wave_r;
    assign frozen      = frozen_r;
    assign ready       = ready_r;

endmodule

// File: tb/tb_wave_sample_prep.sv
// Self-checking bench for wave_sample_prep. A behavioural model keeps the
// input history and the expected output history: live output is the
// window-average of past inputs, frozen output repeats the output DEPTH
// cycles earlier. Honors WAVE_AVG_EN the same way the design does.
`timescale 1ns/1ps
module tb_wave_sample_prep;
    localparam int DEPTH = 1280;
    localparam int HMAX  = 16384;
`ifdef WAVE_AVG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk_sample = 1'b0;
    logic        reset;
    logic        freeze;
    logic [11:0] MIC_in;
    logic [9:0]  wave_sample;
    logic        frozen;
    logic        ready;

    wave_sample_prep #(.AVG_LOG2(2), .DEPTH(DEPTH)) dut (
        .clk_sample (clk_sample),
        .reset      (reset),
        .MIC_in     (MIC_in),
        .freeze     (freeze),
        .wave_sample(wave_sample),
        .frozen     (frozen),
        .ready      (ready)
    );

    always #5 clk_sample = ~clk_sample;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         mic_h [HMAX];
    logic [9:0] out_h [HMAX];
    int         m_n = 0;
    int         m_fill = 0;
    logic       m_f1 = 1'b0;
    logic       m_fz = 1'b0;
    logic       m_frozen = 1'b0;
    logic       m_ready = 1'b0;
    logic [9:0] m_wave = 10'd0;

    function automatic int mic_at(int j);
        return (j >= 1) ? mic_h[j] : 0;
    endfunction

    // Expected live output after edge n (edges counted from reset release).
    function automatic int live(int n);
        int sum;
        sum = 0;
`ifdef WAVE_AVG_EN
        for (int j = n - 5; j <= n - 2; j++) sum += mic_at(j);
        return sum / 16;
`else
        sum = mic_at(n - 1);
        return sum / 4;
`endif
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge,
    // then move 1ns past the edge for sampling/driving.
    task automatic tick();
        logic nxt;
        int   idx;
        @(posedge clk_sample);
        if (reset) begin
            m_n = 0; m_fill = 0; m_f1 = 1'b0; m_fz = 1'b0;
            m_frozen = 1'b0; m_ready = 1'b0; m_wave = 10'd0;
        end else begin
            m_n++;
            if (m_n >= HMAX) begin
                $display("FAIL history_bound n=%0d limit=%0d", m_n, HMAX);
                $fatal(1, "history exhausted");
            end
            mic_h[m_n] = int'(MIC_in);
            nxt = m_frozen ? m_fz : (m_fz && m_ready);
            if (nxt) begin
                idx = m_n - DEPTH;
                m_wave = (idx >= 1) ? out_h[idx] : 10'd0;
            end else begin
                m_wave = 10'(live(m_n));
                if (m_n >= LAT && m_fill < DEPTH) m_fill++;
            end
            m_ready  = (m_fill == DEPTH);
            m_frozen = nxt;
            out_h[m_n] = m_wave;
            m_fz = m_f1;
            m_f1 = freeze;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; freeze = 1'b0; MIC_in = 12'($urandom);
        tick(); tick();
        n_cmp++; if (wave_sample !== 10'd0) begin n_bad++; $display("FAIL reset_wave got=%0d exp=0", wave_sample); end
        n_cmp++; if (frozen !== 1'b0) begin n_bad++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    endtask

    task automatic test_constant();
        int rise;
        rise = -1;
        reset = 1'b0; freeze = 1'b0; MIC_in = 12'h800;
        for (int i = 1; i <= 1400 && rise < 0; i++) begin
            tick();
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL const_wave cyc=%0d got=%0d exp=%0d", i, wave_sample, m_wave); end
            n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL const_ready cyc=%0d got=%b exp=%b", i, ready, m_ready); end
            if (i == 10) begin
                n_cmp++; if (wave_sample !== 10'd512) begin n_bad++; $display("FAIL const_midscale got=%0d exp=512", wave_sample); end
            end
            if (ready === 1'b1) rise = i;
        end
        n_cmp++; if (rise != DEPTH + LAT - 1) begin n_bad++; $display("FAIL const_ready_edge got=%0d exp=%0d", rise, DEPTH + LAT - 1); end
    endtask

    task automatic test_step();
        logic [9:0] exp_seq [8];
`ifdef WAVE_AVG_EN
        exp_seq = '{10'd0, 10'd0, 10'd255, 10'd511, 10'd767, 10'd1023, 10'd1023, 10'd1023};
`else
        exp_seq = '{10'd0, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023};
`endif
        reset = 1'b1; freeze = 1'b0; MIC_in = 12'h000;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        MIC_in = 12'hFFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (wave_sample !== exp_seq[i]) begin n_bad++; $display("FAIL step_seq i=%0d got=%0d exp=%0d", i, wave_sample, exp_seq[i]); end
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL step_model i=%0d got=%0d exp=%0d", i, wave_sample, m_wave); end
        end
    endtask

    task automatic test_freeze_before_ready();
        int r_rdy;
        int r_frz;
        r_rdy = -1; r_frz = -1;
        reset = 1'b1; freeze = 1'b0; MIC_in = 12'h000;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 1500 && r_frz < 0; i++) begin
            if (i == 10) freeze = 1'b1;
            MIC_in = 12'(i);
            tick();
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL early_wave cyc=%0d got=%0d exp=%0d", i, wave_sample, m_wave); end
            n_cmp++; if (frozen !== m_frozen) begin n_bad++; $display("FAIL early_frozen cyc=%0d got=%b exp=%b", i, frozen, m_frozen); end
            n_cmp++; if (ready !== m_ready) begin n_bad++; $display("FAIL early_ready cyc=%0d got=%b exp=%b", i, ready, m_ready); end
            if (ready === 1'b1 && r_rdy < 0) r_rdy = i;
            if (frozen === 1'b1) r_frz = i;
        end
        n_cmp++; if (r_rdy != DEPTH + LAT - 1) begin n_bad++; $display("FAIL early_ready_edge got=%0d exp=%0d", r_rdy, DEPTH + LAT - 1); end
        n_cmp++; if (r_frz != DEPTH + LAT) begin n_bad++; $display("FAIL early_freeze_edge got=%0d exp=%0d", r_frz, DEPTH + LAT); end
    endtask

    task automatic test_replay();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            MIC_in = 12'($urandom);
            tick();
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL replay_wave i=%0d got=%0d exp=%0d", i, wave_sample, m_wave); end
            n_cmp++; if (frozen !== 1'b1) begin n_bad++; $display("FAIL replay_frozen i=%0d got=%b exp=1", i, frozen); end
        end
    endtask

    task automatic test_unfreeze();
        freeze = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            MIC_in = 12'($urandom);
            tick();
            n_cmp++; if (frozen !== (k < 3)) begin n_bad++; $display("FAIL unfreeze_edge k=%0d got=%b exp=%b", k, frozen, (k < 3)); end
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL unfreeze_wave k=%0d got=%0d exp=%0d", k, wave_sample, m_wave); end
        end
        for (int i = 0; i < 40; i++) begin
            MIC_in = 12'($urandom);
            tick();
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL live_wave i=%0d got=%0d exp=%0d", i, wave_sample, m_wave); end
            n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL live_ready i=%0d got=%b exp=1", i, ready); end
        end
    endtask

    task automatic test_refreeze();
        freeze = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            MIC_in = 12'($urandom);
            tick();
            if (k <= 3) begin
                n_cmp++; if (frozen !== (k == 3)) begin n_bad++; $display("FAIL refreeze_edge k=%0d got=%b exp=%b", k, frozen, (k == 3)); end
            end
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL refreeze_wave k=%0d got=%0d exp=%0d", k, wave_sample, m_wave); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 305; i++) begin
            freeze = (i >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
            MIC_in = 12'($urandom);
            tick();
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL toggle_wave i=%0d got=%0d exp=%0d", i, wave_sample, m_wave); end
            n_cmp++; if (frozen !== m_frozen) begin n_bad++; $display("FAIL toggle_frozen i=%0d got=%b exp=%b", i, frozen, m_frozen); end
        end
    endtask

    task automatic test_reset_mid_freeze();
        int r_frz;
        r_frz = -1;
        n_cmp++; if (frozen !== m_frozen) begin n_bad++; $display("FAIL pre_reset_frozen got=%b exp=%b", frozen, m_frozen); end
        reset = 1'b1;
        tick();
        n_cmp++; if (frozen !== 1'b0) begin n_bad++; $display("FAIL midrst_frozen got=%b exp=0", frozen); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got=%b exp=0", ready); end
        n_cmp++; if (wave_sample !== 10'd0) begin n_bad++; $display("FAIL midrst_wave got=%0d exp=0", wave_sample); end
        reset = 1'b0;
        for (int i = 1; i <= 1500 && r_frz < 0; i++) begin
            MIC_in = 12'($urandom);
            tick();
            n_cmp++; if (frozen !== m_frozen) begin n_bad++; $display("FAIL refill_frozen cyc=%0d got=%b exp=%b", i, frozen, m_frozen); end
            n_cmp++; if (wave_sample !== m_wave) begin n_bad++; $display("FAIL refill_wave cyc=%0d got=%0d exp=%0d", i, wave_sample, m_wave); end
            if (frozen === 1'b1) r_frz = i;
        end
        n_cmp++; if (r_frz != DEPTH + LAT) begin n_bad++; $display("FAIL refill_freeze_edge got=%0d exp=%0d", r_frz, DEPTH + LAT); end
    endtask

    initial begin
        reset = 1'b1; freeze = 1'b0; MIC_in = 12'h000;
        test_reset();
        test_constant();
        test_step();
        test_freeze_before_ready();
        test_replay();
        test_unfreeze();
        test_refreeze();
        test_back_to_back();
        test_reset_mid_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
